// File: rtl/multibyte_add_sequencer_if.sv
// Purpose: requester and byte-adder connections of multibyte_add_sequencer.
// Latency: none (wires only).
// Backpressure: none; requests are simply ignored while busy is high.
//
// Signals
//   start, sub, cin, op_a, op_b        : requester -> sequencer
//   busy, done, result, cout           : sequencer -> requester
//   adder_add, adder_aug, adder_preC   : sequencer -> external 8-bit adder
//   adder_sum, adder_proC              : external 8-bit adder -> sequencer
// The slave modport is the sequencer's view, the master modport the
// view of whoever drives the requests and hosts the adder.
interface multibyte_add_sequencer_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic [7:0]   adder_add;
    logic [7:0]   adder_aug;
    logic         adder_preC;
    logic [7:0]   adder_sum;
    logic         adder_proC;

    modport slave (
        input  start, sub, cin, op_a, op_b, adder_sum, adder_proC,
        output busy, done, result, cout, adder_add, adder_aug, adder_preC
    );

    modport master (
        output start, sub, cin, op_a, op_b, adder_sum, adder_proC,
        input  busy, done, result, cout, adder_add, adder_aug, adder_preC
    );
endinterface

// File: rtl/multibyte_add_sequencer.sv
// Purpose: runs one external 8-bit adder over NBYTES-wide operands, LSB byte first.
// Latency: NBYTES RUN cycles after the accepting edge, then a one-cycle done pulse.
// Backpressure: start is only taken in IDLE; all request inputs are ignored while busy.
//
// Ports
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   bus        : slave side of multibyte_add_sequencer_if (request, result, adder drive)
// Subtraction is done as A + ~B + 1, so cout=1 means "no borrow".
module multibyte_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    multibyte_add_sequencer_if.slave        bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  result_q;
    logic          cout_q;
    logic          busy_q;
    logic          done_q;

    logic [7:0]    add_byte;
    logic [7:0]    aug_byte;

    // Current byte of each latched operand; b_q is already inverted for subtract.
    always_comb begin
        add_byte = 8'h00;
        aug_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) begin
                add_byte = a_q[8*i +: 8];
                aug_byte = b_q[8*i +: 8];
            end
        end
    end

    // The adder is only driven while a byte is actually being processed.
    assign bus.adder_add  = (state == S_RUN) ? add_byte : 8'h00;
    assign bus.adder_aug  = (state == S_RUN) ? aug_byte : 8'h00;
    assign bus.adder_preC = (state == S_RUN) ? carry    : 1'b0;

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.op_a;
                        b_q      <= bus.sub ? ~bus.op_b : bus.op_b;
                        // Subtract's "+1" enters as the initial carry.
                        carry    <= bus.sub ? 1'b1 : bus.cin;
                        idx      <= '0;
                        result_q <= '0;
                        busy_q   <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NBYTES; i++) begin
                        if (idx == IW'(i)) begin
                            result_q[8*i +: 8] <= bus.adder_sum;
                        end
                    end
                    carry <= bus.adder_proC;
                    if (idx == LAST_IDX) begin
                        idx    <= '0;
                        cout_q <= bus.adder_proC;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here, so a held
                    // start produces one op every NBYTES+2 cycles.
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed bench for multibyte_add_sequencer with NBYTES=4 and a behavioural
// 8-bit ripple adder hooked to the adder_* signals.
module tb_multibyte_add_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    multibyte_add_sequencer_if #(.NBYTES(4)) bus();

    multibyte_add_sequencer #(.NBYTES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External 8-bit adder (fullAdder8bit equivalent).
    logic [8:0] adder_full;
    assign adder_full     = {1'b0, bus.adder_add} + {1'b0, bus.adder_aug} + {8'b0, bus.adder_preC};
    assign bus.adder_sum  = adder_full[7:0];
    assign bus.adder_proC = adder_full[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op, wait (bounded) for done, check timing and result.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic c,
                         input logic [31:0] exp_res, input logic exp_cout);
        int n;
        int busy_cnt;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        bus.cin   = c;
        bus.start = 1'b1;
        tick();                         // accepting edge
        bus.start = 1'b0;
        n = 1;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && n < 20) begin
            tick();
            n++;
            if (bus.busy) busy_cnt++;
        end
        chk({tag, "_lat"},    n, 32'd5);
        chk({tag, "_busy"},   busy_cnt, 32'd5);
        chk({tag, "_result"}, bus.result, exp_res);
        chk({tag, "_cout"},   {31'b0, bus.cout}, {31'b0, exp_cout});
        tick();
        chk({tag, "_idle"},   {30'b0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        int n;
        int t1;
        int t2;
        int dcount;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;

        // 1. reset state
        #2 rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_busy_done", {30'b0, bus.busy, bus.done}, 32'd0);
        chk("rst_result",    bus.result, 32'd0);
        chk("rst_cout",      {31'b0, bus.cout}, 32'd0);
        chk("rst_adder",     {15'b0, bus.adder_add, bus.adder_aug, bus.adder_preC}, 32'd0);

        // First RUN cycle drives byte 0 to the adder.
        bus.op_a = 32'h000000FF; bus.op_b = 32'h00000001; bus.sub = 1'b0; bus.cin = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("run0_adder", {15'b0, bus.adder_add, bus.adder_aug, bus.adder_preC}, {15'b0, 8'hFF, 8'h01, 1'b0});
        n = 0;
        while (!bus.done && n < 20) begin tick(); n++; end
        chk("run0_result", bus.result, 32'h00000100);
        tick();

        // 2. add with ripple, timing
        do_op("add_ripple", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0);
        // 3. overflow and carry-in
        do_op("add_ovf",    32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1);
        do_op("add_cin",    32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0);
        // 4. subtract (cin=1 must have no effect)
        do_op("sub_pos",    32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1);
        do_op("sub_neg",    32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0);

        // 5a. inputs ignored while busy
        bus.op_a = 32'h00000010; bus.op_b = 32'h00000020; bus.sub = 1'b0; bus.cin = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.op_a = 32'hFFFF0000; bus.op_b = 32'h0000FFFF; bus.sub = 1'b1; bus.cin = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 20) begin tick(); n++; end
        chk("busy_ignore_result", bus.result, 32'h00000030);
        chk("busy_ignore_cout",   {31'b0, bus.cout}, 32'd0);
        tick();

        // 5b. start held high -> done every 6 cycles
        bus.op_a = 32'h00000001; bus.op_b = 32'h00000002; bus.sub = 1'b0; bus.cin = 1'b0;
        bus.start = 1'b1;
        n = 0;
        while (!bus.done && n < 20) begin tick(); n++; end
        t1 = cyc;
        tick();
        n = 0;
        while (!bus.done && n < 20) begin tick(); n++; end
        t2 = cyc;
        bus.start = 1'b0;
        chk("b2b_period", t2 - t1, 32'd6);
        chk("b2b_result", bus.result, 32'h00000003);
        tick();
        tick();

        // 6. reset during the second RUN cycle
        bus.op_a = 32'h000000AB; bus.op_b = 32'h00000001; bus.sub = 1'b0; bus.cin = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("abort_state",  {30'b0, bus.busy, bus.done}, 32'd0);
        chk("abort_result", bus.result, 32'd0);
        chk("abort_adder",  {15'b0, bus.adder_add, bus.adder_aug, bus.adder_preC}, 32'd0);
        tick();
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done) dcount++;
        end
        chk("abort_no_done", dcount, 32'd0);
        do_op("post_abort", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
